axis_pattern_gen: RTL and testbench
===================================

# axis_pattern_gen

Parametrised AXI-Stream test-pattern source for bring-up of the USB FIFO path and downstream stream consumers. It generates framed packets of configurable length in one of four data patterns, with a programmable idle gap between packets. It fully honours tready backpressure and sits directly in front of the ft232h sys_axis sink or any other AXIS consumer. It replaces hand-written single-byte counter state machines in example tops.

## Interface
- DATA_WIDTH, 8: tdata width in bits, ≥ 2.
- LEN_WIDTH, 16: width of pkt_len and of the beat counter.
- GAP_WIDTH, 8: width of gap_cycles.
- LFSR_TAPS, 8'hB8: Galois tap mask, DATA_WIDTH bits.
- clk  input  1  stream clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  run request.
- mode  input  2  pattern select: 0 COUNT, 1 CONST, 2 LFSR, 3 WALK.
- seed  input  DATA_WIDTH  initial pattern value; the CONST value.
- pkt_len  input  LEN_WIDTH  beats per packet; 0 is treated as 1.
- gap_cycles  input  GAP_WIDTH  idle cycles between packets.
- m_axis_tdata  output  DATA_WIDTH  beat data.
- m_axis_tvalid  output  1  beat valid.
- m_axis_tready  input  1  sink ready.
- m_axis_tlast  output  1  high on the final beat of a packet.
- m_axis_tkeep  output  DATA_WIDTH/8 (min 1)  constant all ones.
- busy  output  1  state ≠ IDLE.
- pkt_count  output  32  completed packets; wraps at 2^32.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE
  - tvalid = 0.
  - On enable = 1: latch mode, pkt_len, gap_cycles; load the pattern register from seed; clear the beat counter; go to SEND.
  - In LFSR mode, seed = 0 loads 1. In WALK mode, seed = 0 loads 1 (LSB one-hot).
- SEND
  - tvalid = 1; tdata = pattern register; tlast = (beat counter == len−1).
  - On handshake (tvalid & tready):
    - advance the pattern;
    - increment the beat counter;
    - if tlast: increment pkt_count, then go to GAP if gap ≠ 0, else handle end-of-packet directly.
- End-of-packet (GAP expiry, or gap = 0):
  - If enable = 1: relatch pkt_len, gap_cycles and mode; clear the beat counter; enter SEND. The pattern register continues and is not reseeded.
  - If enable = 0: go to IDLE.
- GAP
  - tvalid = 0.
  - Count gap_cycles clocks, then apply the end-of-packet rule.
- Pattern advance, applied on each accepted beat only:
  - COUNT: +1 modulo 2^DATA_WIDTH.
  - CONST: hold.
  - LFSR: next = (s >> 1) ^ (s[0] ? LFSR_TAPS : 0).
  - WALK: rotate left by 1.
- Config changes mid-packet are ignored until the next packet boundary.
- Deasserting enable mid-packet never truncates; the packet completes, then the block goes to IDLE.

## Timing
- Reset values: tvalid 0, tlast 0, tdata 0, busy 0, pkt_count 0, state IDLE. tkeep is constant all ones.
- All outputs are registered.
- Latency: enable sampled high in IDLE at cycle N gives tvalid = 1 with tdata = seed at cycle N+1.
- AXIS rules:
  - Once tvalid is asserted, tdata and tlast hold stable until the handshake.
  - tvalid never drops without a handshake.
  - tvalid does not depend combinationally on tready.
- Throughput: one beat per clock while tready = 1.
- With gap = 0 and enable held, tvalid stays high across packet boundaries with no bubble.
- With gap = G > 0: exactly G cycles of tvalid = 0 between the tlast handshake and the next first beat.
- pkt_count updates in the cycle after the tlast handshake.
- busy is high from the cycle after enable is sampled until IDLE is re-entered.
- Reset mid-packet: all outputs return to reset values on the next edge. No partial-packet completion.

## Structure
- Package axis_pattern_pkg holds:
  - state_t enum (IDLE, SEND, GAP);
  - pattern_mode_t enum (COUNT = 0, CONST = 1, LFSR = 2, WALK = 3);
  - default-tap constant.
- One sub-module, axis_pattern_step: combinational next-pattern function (mode, current value, taps → next value). It is reused by the checker model in the bench.
- The top-level FSM, counters and output registers live in axis_pattern_gen.

## Test plan
- COUNT, seed 0x45, pkt_len 4, gap 0, tready = 1, enable held → tdata 0x45, 46, 47, 48 (tlast on 0x48), then 0x49 with no bubble; pkt_count 1 after the first packet.
- LFSR, seed 0x01, taps 0xB8, pkt_len 3, random 50% tready → beats 0x01, 0xB8, 0x5C. Data and tlast stay stable through every stall.
- WALK, seed 0, pkt_len 9, DATA_WIDTH 8 → beats 0x01, 02, 04 … 80, 01 (tlast on the last 0x01).
- CONST, seed 0xA5, pkt_len 2, gap 3 → beats A5, A5/tlast, then exactly 3 cycles tvalid = 0, then A5 again.
- Boundaries:
  - pkt_len 0 → single-beat packets, tlast on every beat.
  - enable dropped on beat 2 of 5 → remaining beats complete, then IDLE with busy = 0.
  - pkt_len changed mid-packet → takes effect on the next packet only.
- Reset asserted during a stalled SEND beat → next edge gives tvalid 0, tlast 0, pkt_count 0, busy 0. Re-enable restarts from seed.

Source files
------------

// File: rtl/axis_pattern_pkg.sv
// -----------------------------------------------------------------------------
// axis_pattern_pkg
// Shared types and constants for the AXI-Stream test-pattern generator:
//   state_t        - generator FSM states
//   pattern_mode_t - data pattern selector (encoding matches the mode input)
//   DEFAULT_TAPS   - default Galois LFSR tap mask for 8-bit data
// -----------------------------------------------------------------------------
package axis_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        COUNT = 2'd0,
        CONST = 2'd1,
        LFSR  = 2'd2,
        WALK  = 2'd3
    } pattern_mode_t;

    localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

endpackage

// File: rtl/axis_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen_if
// AXI-Stream bus bundle for the pattern generator.
//   tdata  - beat data (DATA_WIDTH bits)
//   tvalid - beat valid (driven by master)
//   tready - sink ready (driven by slave)
//   tlast  - final beat of a packet
//   tkeep  - byte enables, DATA_WIDTH/8 bits with a minimum of one
// Modports: master (source side), slave (sink side).
// -----------------------------------------------------------------------------
interface axis_pattern_gen_if #(
    parameter int DATA_WIDTH = 8
) ();
    localparam int KEEP_WIDTH = (DATA_WIDTH / 8 < 1) ? 1 : DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [KEEP_WIDTH-1:0] tkeep;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tkeep,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tkeep,
        output tready
    );
endinterface

// File: rtl/axis_pattern_step.sv
// -----------------------------------------------------------------------------
// axis_pattern_step
// Combinational next-pattern function.
//   mode_i  - pattern selector
//   value_i - current pattern value
//   taps_i  - Galois LFSR tap mask
//   next_o  - pattern value for the following beat
// -----------------------------------------------------------------------------
module axis_pattern_step
    import axis_pattern_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  pattern_mode_t         mode_i,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic [DATA_WIDTH-1:0] taps_i,
    output logic [DATA_WIDTH-1:0] next_o
);

    always_comb begin
        next_o = value_i;
        case (mode_i)
            COUNT:   next_o = value_i + 1'b1;
            CONST:   next_o = value_i;
            // Galois form: shift right, fold the taps in when a one falls out
            LFSR:    next_o = (value_i >> 1) ^ (value_i[0] ? taps_i : '0);
            WALK:    next_o = {value_i[DATA_WIDTH-2:0], value_i[DATA_WIDTH-1]};
            default: next_o = value_i;
        endcase
    end

endmodule

// File: rtl/axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen
// AXI-Stream test-pattern source producing framed packets of configurable
// length in one of four data patterns, with a programmable idle gap.
//   clk          - stream clock, all logic on posedge
//   rst          - synchronous active-high reset
//   enable_i     - run request; sampled at packet boundaries
//   mode_i       - 0 COUNT, 1 CONST, 2 LFSR, 3 WALK
//   seed_i       - initial pattern value (the CONST value)
//   pkt_len_i    - beats per packet, 0 treated as 1
//   gap_cycles_i - idle cycles between packets
//   m_axis       - AXI-Stream master (tdata/tvalid/tready/tlast/tkeep)
//   busy_o       - high whenever the generator is not idle
//   pkt_count_o  - completed packets, wraps at 2^32
// -----------------------------------------------------------------------------
module axis_pattern_gen
    import axis_pattern_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LEN_WIDTH  = 16,
    parameter int                    GAP_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS  = DATA_WIDTH'(DEFAULT_TAPS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable_i,
    input  logic [1:0]            mode_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    input  logic [LEN_WIDTH-1:0]  pkt_len_i,
    input  logic [GAP_WIDTH-1:0]  gap_cycles_i,
    axis_pattern_gen_if.master    m_axis,
    output logic                  busy_o,
    output logic [31:0]           pkt_count_o
);

    // LFSR and WALK would lock up on an all-zero value, so zero seeds become 1
    function automatic logic [DATA_WIDTH-1:0] seed_load(
        input pattern_mode_t         m,
        input logic [DATA_WIDTH-1:0] s
    );
        if ((m == LFSR || m == WALK) && s == '0) begin
            return DATA_WIDTH'(1);
        end
        return s;
    endfunction

    // Index of the final beat; a zero length behaves as a single-beat packet
    function automatic logic [LEN_WIDTH-1:0] last_index(input logic [LEN_WIDTH-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    state_t                state_q,     state_d;
    pattern_mode_t         mode_q,      mode_d;
    logic [LEN_WIDTH-1:0]  last_q,      last_d;
    logic [LEN_WIDTH-1:0]  beat_q,      beat_d;
    logic [GAP_WIDTH-1:0]  gap_q,       gap_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q,   gap_cnt_d;
    logic [DATA_WIDTH-1:0] pat_q,       pat_d;
    logic                  tvalid_q,    tvalid_d;
    logic                  tlast_q,     tlast_d;
    logic                  busy_q,      busy_d;
    logic [31:0]           pkt_count_q, pkt_count_d;

    logic [DATA_WIDTH-1:0] pat_next;
    logic                  eop;
    logic                  load_cfg;

    axis_pattern_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .mode_i (mode_q),
        .value_i(pat_q),
        .taps_i (LFSR_TAPS),
        .next_o (pat_next)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        last_d      = last_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        pat_d       = pat_q;
        pkt_count_d = pkt_count_q;
        eop         = 1'b0;
        load_cfg    = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    load_cfg = 1'b1;
                    pat_d    = seed_load(pattern_mode_t'(mode_i), seed_i);
                    state_d  = SEND;
                end
            end
            SEND: begin
                // tvalid is always high in SEND, so tready alone marks a handshake
                if (m_axis.tready) begin
                    pat_d = pat_next;
                    if (tlast_q) begin
                        pkt_count_d = pkt_count_q + 32'd1;
                        if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end else begin
                            eop = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    eop = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Packet boundary: either continue with freshly latched config (pattern
        // keeps running) or drop back to idle
        if (eop) begin
            if (enable_i) begin
                load_cfg = 1'b1;
                state_d  = SEND;
            end else begin
                state_d  = IDLE;
            end
        end

        if (load_cfg) begin
            mode_d = pattern_mode_t'(mode_i);
            last_d = last_index(pkt_len_i);
            gap_d  = gap_cycles_i;
            beat_d = '0;
        end

        // Outputs are registered from the next state so they line up with it
        tvalid_d = (state_d == SEND);
        tlast_d  = (state_d == SEND) && (beat_d == last_d);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= COUNT;
            last_q      <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            pat_q       <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            busy_q      <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            last_q      <= last_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            pat_q       <= pat_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            busy_q      <= busy_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign m_axis.tdata  = pat_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tkeep  = '1;
    assign busy_o        = busy_q;
    assign pkt_count_o   = pkt_count_q;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_pattern_gen
// Self-checking bench: a behavioural reference model tracks packet phase,
// beat index, gap countdown and pattern value from the documented rules and
// is compared against the generator every cycle; literal expectations pin the
// model on the documented example sequences.
// -----------------------------------------------------------------------------
module tb_axis_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  mode;
    logic [7:0]  seed;
    logic [15:0] pkt_len;
    logic [7:0]  gap;
    logic        busy;
    logic [31:0] pkt_count;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0 always ready, 1 random, 2 never ready
    int cyc = 0;

    typedef struct {
        logic [7:0]  d;
        logic        l;
        logic [31:0] c;
        int          cy;
    } beat_t;
    beat_t beats[$];

    axis_pattern_gen_if #(.DATA_WIDTH(8)) axis_if ();

    axis_pattern_gen #(
        .DATA_WIDTH(8),
        .LEN_WIDTH (16),
        .GAP_WIDTH (8),
        .LFSR_TAPS (8'hB8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable),
        .mode_i      (mode),
        .seed_i      (seed),
        .pkt_len_i   (pkt_len),
        .gap_cycles_i(gap),
        .m_axis      (axis_if),
        .busy_o      (busy),
        .pkt_count_o (pkt_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        case (ready_mode)
            0:       axis_if.tready = 1'b1;
            1:       axis_if.tready = 1'($urandom_range(0, 1));
            default: axis_if.tready = 1'b0;
        endcase
    end

    // ---------------- reference model ----------------
    int          m_phase = 0;   // 0 idle, 1 sending, 2 gap
    logic [7:0]  m_pat = 8'h00;
    int          m_beat = 0;
    int          m_last = 0;
    int          m_gap = 0;
    int          m_left = 0;
    int          m_mode = 0;
    logic [31:0] m_cnt = 32'd0;
    logic        stalled = 1'b0;
    logic [7:0]  stall_d = 8'h00;
    logic        stall_l = 1'b0;

    function automatic logic [7:0] model_next(input int md, input logic [7:0] v);
        int x;
        x = int'(v);
        case (md)
            0:       x = (x + 1) % 256;
            2:       x = (x / 2) ^ ((x % 2 == 1) ? 'hB8 : 0);
            3:       x = ((x * 2) % 256) + (x / 128);
            default: x = x;
        endcase
        return 8'(x);
    endfunction

    task automatic m_latch();
        m_mode = int'(mode);
        m_last = (pkt_len == 16'd0) ? 0 : int'(pkt_len) - 1;
        m_gap  = int'(gap);
        m_beat = 0;
    endtask

    task automatic m_boundary();
        if (enable) begin
            m_latch();
            m_phase = 1;
        end else begin
            m_phase = 0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst && axis_if.tvalid && axis_if.tready)
            beats.push_back('{axis_if.tdata, axis_if.tlast, pkt_count, cyc});
        stalled = !rst && axis_if.tvalid && !axis_if.tready;
        stall_d = axis_if.tdata;
        stall_l = axis_if.tlast;
        if (rst) begin
            m_phase = 0;
            m_pat   = 8'h00;
            m_beat  = 0;
            m_cnt   = 32'd0;
        end else begin
            case (m_phase)
                0: if (enable) begin
                    m_latch();
                    m_pat = ((mode == 2'd2 || mode == 2'd3) && seed == 8'h00) ? 8'h01 : seed;
                    m_phase = 1;
                end
                1: if (axis_if.tready) begin
                    m_pat = model_next(m_mode, m_pat);
                    if (m_beat == m_last) begin
                        m_cnt = m_cnt + 32'd1;
                        if (m_gap > 0) begin
                            m_phase = 2;
                            m_left  = m_gap;
                        end else begin
                            m_boundary();
                        end
                    end else begin
                        m_beat++;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_boundary();
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("tvalid", 32'(axis_if.tvalid), 32'(m_phase == 1));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("pkt_count", pkt_count, m_cnt);
        if (m_phase == 1) begin
            chk("tdata", 32'(axis_if.tdata), 32'(m_pat));
            chk("tlast", 32'(axis_if.tlast), 32'(m_beat == m_last));
        end
        if (stalled) begin
            chk("stall_tvalid", 32'(axis_if.tvalid), 32'd1);
            chk("stall_tdata", 32'(axis_if.tdata), 32'(stall_d));
            chk("stall_tlast", 32'(axis_if.tlast), 32'(stall_l));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start(input logic [1:0] m, input logic [7:0] s,
                         input logic [15:0] l, input logic [7:0] g);
        @(negedge clk);
        beats.delete();
        mode    = m;
        seed    = s;
        pkt_len = l;
        gap     = g;
        enable  = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int max_cyc);
        int k = 0;
        while (beats.size() < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (beats.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_beats got=%0d required=%0d", beats.size(), n);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_beat(input string name, input int i, input logic [7:0] d, input logic l);
        if (i >= beats.size()) begin
            checks++;
            errors++;
            $display("FAIL %s missing beat %0d (have %0d)", name, i, beats.size());
        end else begin
            chk({name, "_data"}, 32'(beats[i].d), 32'(d));
            chk({name, "_last"}, 32'(beats[i].l), 32'(l));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; mode = 2'd0; seed = 8'h00; pkt_len = 16'd1; gap = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(axis_if.tvalid), 32'd0);
        chk("rst_tlast", 32'(axis_if.tlast), 32'd0);
        chk("rst_tdata", 32'(axis_if.tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt_count", pkt_count, 32'd0);
        chk("tkeep", 32'(axis_if.tkeep), 32'd1);
        rst = 1'b0;

        // COUNT, back-to-back packets with no bubble
        start(2'd0, 8'h45, 16'd4, 8'd0);
        wait_beats(6, 50);
        enable = 1'b0;
        wait_idle(100);
        for (int i = 0; i < 5; i++)
            chk_beat("count", i, 8'(8'h45 + i), i == 3);
        if (beats.size() >= 5) begin
            chk("count_pkt1", beats[4].c, 32'd1);
            chk("count_nobubble", 32'(beats[4].cy - beats[3].cy), 32'd1);
        end

        // LFSR with random backpressure, single packet
        do_reset();
        ready_mode = 1;
        start(2'd2, 8'h01, 16'd3, 8'd0);
        @(negedge clk);
        enable = 1'b0;
        wait_beats(3, 300);
        wait_idle(100);
        chk_beat("lfsr0", 0, 8'h01, 1'b0);
        chk_beat("lfsr1", 1, 8'hB8, 1'b0);
        chk_beat("lfsr2", 2, 8'h5C, 1'b1);
        chk("lfsr_count", 32'(beats.size()), 32'd3);

        // WALK from zero seed, nine beats
        do_reset();
        ready_mode = 0;
        start(2'd3, 8'h00, 16'd9, 8'd0);
        @(negedge clk);
        enable = 1'b0;
        wait_beats(9, 50);
        wait_idle(50);
        for (int i = 0; i < 8; i++)
            chk_beat("walk", i, 8'(1 << i), 1'b0);
        chk_beat("walk8", 8, 8'h01, 1'b1);

        // CONST with a 3-cycle gap
        start(2'd1, 8'hA5, 16'd2, 8'd3);
        wait_beats(3, 50);
        enable = 1'b0;
        wait_idle(50);
        chk_beat("const0", 0, 8'hA5, 1'b0);
        chk_beat("const1", 1, 8'hA5, 1'b1);
        chk_beat("const2", 2, 8'hA5, 1'b0);
        if (beats.size() >= 3)
            chk("const_gap", 32'(beats[2].cy - beats[1].cy), 32'd4);

        // pkt_len 0 gives single-beat packets
        start(2'd0, 8'h07, 16'd0, 8'd0);
        wait_beats(3, 50);
        enable = 1'b0;
        wait_idle(50);
        for (int i = 0; i < 3; i++)
            chk_beat("len0", i, 8'(8'h07 + i), 1'b1);

        // enable dropped on beat 2 of 5 under random backpressure
        ready_mode = 1;
        start(2'd0, 8'h10, 16'd5, 8'd0);
        wait_beats(2, 200);
        enable = 1'b0;
        wait_beats(5, 300);
        wait_idle(200);
        chk("drop_beats", 32'(beats.size()), 32'd5);
        chk_beat("drop4", 4, 8'h14, 1'b1);

        // pkt_len change mid-packet takes effect on the next packet
        ready_mode = 0;
        start(2'd0, 8'h20, 16'd3, 8'd0);
        wait_beats(1, 50);
        pkt_len = 16'd2;
        wait_beats(4, 50);
        enable = 1'b0;
        wait_idle(50);
        chk("lenchg_beats", 32'(beats.size()), 32'd5);
        chk_beat("lenchg2", 2, 8'h22, 1'b1);
        chk_beat("lenchg3", 3, 8'h23, 1'b0);
        chk_beat("lenchg4", 4, 8'h24, 1'b1);

        // reset during a stalled beat, then restart from seed
        ready_mode = 2;
        start(2'd0, 8'h33, 16'd4, 8'd0);
        repeat (3) @(negedge clk);
        chk("stall_held", 32'(axis_if.tvalid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", 32'(axis_if.tvalid), 32'd0);
        chk("midrst_tlast", 32'(axis_if.tlast), 32'd0);
        chk("midrst_pkt_count", pkt_count, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        enable = 1'b0;
        ready_mode = 0;
        start(2'd0, 8'h33, 16'd4, 8'd0);
        wait_beats(1, 20);
        enable = 1'b0;
        chk_beat("restart", 0, 8'h33, 1'b0);
        wait_idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
